reg_bank_init: RTL and testbench
================================

REG_BANK_INIT -- requirements
Module: reg_bank_init

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each entry in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of entries (legal range 2..256).
REQ-003 The block SHALL have parameter ADDR_W, default 3, meaning the address width, with 2**ADDR_W >= DEPTH.
REQ-004 The block SHALL have port Clk  input  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port Init  input  1  start a clear sweep of all entries.
REQ-007 The block SHALL have port Ld  input  1  write enable.
REQ-008 The block SHALL have port WAddr  input  ADDR_W  write address.
REQ-009 The block SHALL have port Data  input  WIDTH  write data.
REQ-010 The block SHALL have ports RAddrA and RAddrB  input  ADDR_W  read addresses.
REQ-011 The block SHALL have ports WA and WB  output  WIDTH  read data for ports A and B.
REQ-012 The block SHALL have port Busy  output  1  high while a clear sweep is in progress.
REQ-013 The block SHALL have port Done  output  1  one-cycle pulse on the last sweep cycle.

Function
REQ-014 Reads SHALL be combinational: WA = entry[RAddrA] and WB = entry[RAddrB], 0-cycle latency.
REQ-015 A read address >= DEPTH SHALL return all-zeros.
REQ-016 In IDLE, Ld=1 with WAddr < DEPTH SHALL load Data into entry[WAddr] at the rising edge; WAddr >= DEPTH SHALL change nothing.
REQ-017 The FSM SHALL have two states, IDLE and CLEAR, with a sweep pointer ptr of ADDR_W bits.
REQ-018 IDLE with Init=1 -> CLEAR, with ptr=0; the Init edge SHALL NOT clear any entry itself.
REQ-019 In CLEAR, each cycle SHALL zero entry[ptr] and then increment ptr.
REQ-020 In CLEAR with ptr = DEPTH-1, the FSM SHALL zero that entry, assert Done for that cycle and return to IDLE; a sweep therefore takes exactly DEPTH cycles.
REQ-021 Busy SHALL be 1 in every CLEAR cycle and 0 in IDLE.
REQ-022 Done SHALL be registered-state decoded (CLEAR and ptr = DEPTH-1), never high in IDLE.
REQ-023 In CLEAR, Ld SHALL be ignored; no write is queued or deferred.
REQ-024 Init=1 while in CLEAR SHALL restart the sweep with ptr=0, with no Done for the aborted sweep.
REQ-025 Init=1 and Ld=1 in the same IDLE cycle: Init SHALL win and the write SHALL be dropped.
REQ-026 During CLEAR, reads SHALL return current contents: already-swept entries read 0, and unswept entries keep their old value.

Reset
REQ-027 Rst=1 SHALL immediately, independent of Clk, force all entries to 0, the FSM to IDLE and ptr to 0, giving Busy=0, Done=0, WA=0 and WB=0.
REQ-028 Rst asserted mid-sweep SHALL abort the sweep, with no Done pulse.
REQ-029 After Rst deasserts, the first rising edge SHALL already accept Ld or Init.

Configuration
REQ-030 The macro REG_BANK_INIT_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With REG_BANK_INIT_BYPASS_EN defined, an accepted write (IDLE, Ld=1, no Init, WAddr < DEPTH) SHALL make a read port whose address equals WAddr return Data in that same cycle.
REQ-032 Without REG_BANK_INIT_BYPASS_EN, such a read port SHALL return the old entry value until the next edge.
REQ-033 In neither configuration SHALL forwarding occur for dropped writes (CLEAR, Init collision, out-of-range).

Verification
REQ-034 The bench SHALL cover: Rst pulse, then read all addresses -> WA=WB=0, Busy=0, Done=0.
REQ-035 The bench SHALL cover: write 0xDEADBEEF at addr 5 and 0x12345678 at addr 2; RAddrA=5, RAddrB=2 -> WA=0xDEADBEEF, WB=0x12345678.
REQ-036 The bench SHALL cover: fill all 8 entries, pulse Init -> Busy high for exactly 8 cycles, Done pulses on the 8th, then all reads 0; a Ld during the sweep leaves its entry at 0.
REQ-037 The bench SHALL cover: Init re-pulsed at sweep cycle 4 -> Busy stays high 4+8=12 cycles total, with only one Done.
REQ-038 The bench SHALL cover: Rst asserted at sweep cycle 3 -> Busy=0 at once, no Done, all entries 0.
REQ-039 The bench SHALL cover: Ld to addr 3 with RAddrA=3, Data=0xA5A5A5A5, old value 0 -> WA=0xA5A5A5A5 in that cycle with REG_BANK_INIT_BYPASS_EN, and 0 without it.

Source files
------------

// File: rtl/reg_bank_init_if.sv
// Register-bank access bundle: write port, two read ports and sweep status.
interface reg_bank_init_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
);
  logic              Init;
  logic              Ld;
  logic [ADDR_W-1:0] WAddr;
  logic [WIDTH-1:0]  Data;
  logic [ADDR_W-1:0] RAddrA;
  logic [ADDR_W-1:0] RAddrB;
  logic [WIDTH-1:0]  WA;
  logic [WIDTH-1:0]  WB;
  logic              Busy;
  logic              Done;

  modport master (
    output Init, Ld, WAddr, Data, RAddrA, RAddrB,
    input  WA, WB, Busy, Done
  );

  modport slave (
    input  Init, Ld, WAddr, Data, RAddrA, RAddrB,
    output WA, WB, Busy, Done
  );
endinterface

// File: rtl/reg_bank_init.sv
// Register bank with two combinational read ports and a sequential clear sweep.
// Optional macro REG_BANK_INIT_BYPASS_EN forwards an accepted write to matching read ports.
module reg_bank_init #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic             Clk,
  input logic             Rst,
  reg_bank_init_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_acc;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;

  // Init beats Ld, and nothing is written while a sweep runs.
  assign wr_acc = (state == IDLE) && bus.Ld && !bus.Init &&
                  ({1'b0, bus.WAddr} < DEPTH_C);

  assign bus.Busy = (state == CLEAR);
  assign bus.Done = (state == CLEAR) && (ptr == LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_acc && (bus.WAddr == ADDR_W'(i)))
          mem[i] <= bus.Data;
        else if ((state == CLEAR) && (ptr == ADDR_W'(i)))
          mem[i] <= '0;
      end
      case (state)
        IDLE: begin
          if (bus.Init) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          if (bus.Init) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
      endcase
    end
  end

  // Out-of-range addresses match no entry and read back zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.RAddrA == ADDR_W'(i)) rd_a = mem[i];
      if (bus.RAddrB == ADDR_W'(i)) rd_b = mem[i];
    end
  end

`ifdef REG_BANK_INIT_BYPASS_EN
  assign bus.WA = (wr_acc && (bus.RAddrA == bus.WAddr)) ? bus.Data : rd_a;
  assign bus.WB = (wr_acc && (bus.RAddrB == bus.WAddr)) ? bus.Data : rd_b;
`else
  assign bus.WA = rd_a;
  assign bus.WB = rd_b;
`endif

endmodule

// File: tb/tb_reg_bank_init.sv
// Directed self-checking bench for reg_bank_init (default 32x8 configuration).
module tb_reg_bank_init;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt;
  int   done_cnt;
  int   done_at;
  logic [31:0] exp_byp;

  reg_bank_init_if #(.WIDTH(32), .ADDR_W(3)) bus ();

  reg_bank_init #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.RAddrA = 3'(a);
      bus.RAddrB = 3'(7 - a);
      #1;
      chk({tag, "_wa"}, bus.WA, 32'h0);
      chk({tag, "_wb"}, bus.WB, 32'h0);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    @(negedge Clk);
    bus.Ld = 1'b1; bus.WAddr = a; bus.Data = d;
    @(negedge Clk);
    bus.Ld = 1'b0;
  endtask

  initial begin
    bus.Init = 1'b0; bus.Ld = 1'b0; bus.WAddr = '0; bus.Data = '0;
    bus.RAddrA = '0; bus.RAddrB = '0;

    // Reset state
    #3;
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    read_all_zero("rst_read");
    @(negedge Clk);
    Rst = 1'b0;

    // Basic write/read
    write(3'd5, 32'hDEADBEEF);
    write(3'd2, 32'h12345678);
    bus.RAddrA = 3'd5; bus.RAddrB = 3'd2; #1;
    chk("wr_a5", bus.WA, 32'hDEADBEEF);
    chk("wr_b2", bus.WB, 32'h12345678);

    // Full sweep with a Ld during it
    for (int i = 0; i < 8; i++) write(3'(i), 32'h1000_0000 + 32'(i));
    bus.Init = 1'b1;
    @(negedge Clk);
    bus.Init = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) begin
        bus.Ld = 1'b1; bus.WAddr = 3'd1; bus.Data = 32'hFFFF_0001; bus.RAddrA = 3'd1;
        #1;
        chk("sweep_ld_nofwd", bus.WA, 32'h0);
      end else begin
        bus.Ld = 1'b0;
      end
      if (c == 3) begin
        bus.RAddrA = 3'd0; bus.RAddrB = 3'd7; #1;
        chk("sweep_swept", bus.WA, 32'h0);
        chk("sweep_unswept", bus.WB, 32'h1000_0007);
      end
      #1;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin done_cnt++; done_at = c; end
      @(negedge Clk);
    end
    bus.Ld = 1'b0;
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("sweep_done_count", 32'(done_cnt), 32'd1);
    chk("sweep_done_at", 32'(done_at), 32'd8);
    read_all_zero("sweep_read");

    // Restart at sweep cycle 4
    write(3'd6, 32'h6666_6666);
    bus.Init = 1'b1;
    @(negedge Clk);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      bus.Init = (c == 4);
      #1;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin done_cnt++; done_at = c; end
      @(negedge Clk);
    end
    bus.Init = 1'b0;
    chk("restart_busy_cycles", 32'(busy_cnt), 32'd12);
    chk("restart_done_count", 32'(done_cnt), 32'd1);
    chk("restart_done_at", 32'(done_at), 32'd12);

    // Reset mid-sweep
    write(3'd4, 32'h5555_5555);
    write(3'd7, 32'h7777_7777);
    bus.Init = 1'b1;
    @(negedge Clk);
    bus.Init = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("midrst_busy_before", 32'(bus.Busy), 32'h1);
    Rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.Busy), 32'h0);
    chk("midrst_done", 32'(bus.Done), 32'h0);
    read_all_zero("midrst_read");

    // First edge after reset accepts Ld; forwarding depends on the build
    @(negedge Clk);
    Rst = 1'b0;
    bus.Ld = 1'b1; bus.WAddr = 3'd3; bus.Data = 32'hA5A5A5A5; bus.RAddrA = 3'd3;
`ifdef REG_BANK_INIT_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    #1;
    chk("bypass_same_cycle", bus.WA, exp_byp);
    chk("postrst_idle_done", 32'(bus.Done), 32'h0);
    @(negedge Clk);
    bus.Ld = 1'b0;
    #1;
    chk("postrst_write", bus.WA, 32'hA5A5A5A5);

    // Init and Ld together: write dropped, no forwarding
    @(negedge Clk);
    bus.Init = 1'b1; bus.Ld = 1'b1; bus.WAddr = 3'd4; bus.Data = 32'h0000_0077;
    bus.RAddrA = 3'd4;
    #1;
    chk("collide_nofwd", bus.WA, 32'h0);
    @(negedge Clk);
    bus.Init = 1'b0; bus.Ld = 1'b0;
    #1;
    chk("collide_busy", 32'(bus.Busy), 32'h1);
    for (int c = 0; c < 10; c++) @(negedge Clk);
    #1;
    chk("collide_dropped", bus.WA, 32'h0);
    chk("collide_idle", 32'(bus.Busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
